// File: rtl/spi_crc_pkg.sv
// ---------------------------------------------------------------------------
// spi_crc_pkg
// Shared constants for the SPI block CRC sequencer:
//   - CRC16-CCITT polynomial and initial value (MSB-first, no reflection,
//     no final XOR)
//   - controller state encoding
// ---------------------------------------------------------------------------
package spi_crc_pkg;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_CRC_HI = 3'd2,
      ST_CRC_LO = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage : spi_crc_pkg

// File: rtl/spi_crc16_step.sv
// ---------------------------------------------------------------------------
// spi_crc16_step
// Purely combinational CRC16-CCITT byte step. The byte is folded into the
// top of the register and then shifted out MSB-first over eight bit steps.
//
// Ports:
//   crc_in   [15:0]  current CRC register value
//   data     [7:0]   byte to absorb
//   crc_next [15:0]  CRC after absorbing data
// ---------------------------------------------------------------------------
module spi_crc16_step
   import spi_crc_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_next
);

   logic [15:0] acc;

   // NOTE: acc is a combinational scratch variable that is updated several
   // times within one evaluation, so it uses blocking assignments; state
   // registers elsewhere use non-blocking assignments.
   always_comb begin
      acc = crc_in ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (acc[15]) acc = {acc[14:0], 1'b0} ^ CRC_POLY;
         else         acc = {acc[14:0], 1'b0};
      end
      crc_next = acc;
   end

endmodule : spi_crc16_step

// File: rtl/spi_crc_block_ctrl.sv
// ---------------------------------------------------------------------------
// spi_crc_block_ctrl
// Frames one block of BLOCK_LEN data bytes between the byte FIFO and the SPI
// shifter. Data bytes pass straight through while the CRC16-CCITT is
// accumulated. In write mode the two CRC bytes (high first) are appended to
// the output stream; in read mode the two trailing CRC bytes are consumed
// from the input stream and compared. One done pulse is issued per block.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle pulse, begins a block (IDLE only)
//   wr_mode              sampled at start: 1 = generate CRC, 0 = check CRC
//   abort                cancels the block in progress
//   in_data/valid/ready  input byte stream
//   out_data/valid/ready output byte stream
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse at block end
//   crc_ok               CRC check result (write mode: 1), held until start
//   crc_val              computed CRC, held until next block completes
// ---------------------------------------------------------------------------
module spi_crc_block_ctrl
   import spi_crc_pkg::*;
#(
   parameter int BLOCK_LEN = 512,
   parameter int CNT_W     = 12
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        wr_mode,
   input  logic        abort,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        crc_ok,
   output logic [15:0] crc_val
);

   state_t            state_q, state_d;
   logic              wr_q;
   logic [15:0]       crc_q;
   logic [15:0]       crc_step;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        rx_hi_q;
   logic              data_hs;
   logic              last_byte;

   spi_crc16_step u_step (
      .crc_in   (crc_q),
      .data     (in_data),
      .crc_next (crc_step)
   );

   // In DATA the input side is ready exactly when the output side is, so a
   // data handshake is in_valid & out_ready.
   assign data_hs   = (state_q == ST_DATA) && in_valid && out_ready;
   assign last_byte = (cnt_q == CNT_W'(BLOCK_LEN - 1));

   // NOTE: every output and next-state variable gets a default before the
   // case statement so no path through this block can infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      done      = 1'b0;
      busy      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_DATA;
         end
         ST_DATA: begin
            out_data  = in_data;
            out_valid = in_valid;
            in_ready  = out_ready;
            if (data_hs && last_byte) state_d = ST_CRC_HI;
         end
         ST_CRC_HI: begin
            if (wr_q) begin
               out_data  = crc_q[15:8];
               out_valid = 1'b1;
               if (out_ready) state_d = ST_CRC_LO;
            end else begin
               in_ready = 1'b1;
               if (in_valid) state_d = ST_CRC_LO;
            end
         end
         ST_CRC_LO: begin
            if (wr_q) begin
               out_data  = crc_q[7:0];
               out_valid = 1'b1;
               if (out_ready) state_d = ST_DONE;
            end else begin
               in_ready = 1'b1;
               if (in_valid) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // abort overrides every transition out of a non-IDLE state, including
      // the completion of DONE, so an aborted block never reports done.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         done    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         rx_hi_q <= 8'h00;
         crc_val <= 16'h0000;
         crc_ok  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE) begin
            if (start) begin
               wr_q   <= wr_mode;
               crc_q  <= CRC_INIT;
               cnt_q  <= '0;
               crc_ok <= 1'b0;
            end
         end else if (abort) begin
            // Any byte accepted in the abort cycle is dropped from the CRC.
            crc_ok <= 1'b0;
         end else begin
            case (state_q)
               ST_DATA: begin
                  if (data_hs) begin
                     crc_q <= crc_step;
                     cnt_q <= last_byte ? '0 : cnt_q + 1'b1;
                  end
               end
               ST_CRC_HI: begin
                  if (!wr_q && in_valid) rx_hi_q <= in_data;
               end
               ST_CRC_LO: begin
                  if (!wr_q && in_valid) crc_ok <= ({rx_hi_q, in_data} == crc_q);
               end
               ST_DONE: begin
                  crc_val <= crc_q;
                  if (wr_q) crc_ok <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule : spi_crc_block_ctrl

// File: tb/tb_spi_crc_block_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_crc_block_ctrl
// Two instances: index 0 with BLOCK_LEN=9, index 1 with BLOCK_LEN=512.
// Stimulus pushes expected output bytes and expected block results into
// per-instance queues; a negedge monitor pops and compares them whenever a
// byte handshake or a done pulse is observed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_crc_block_ctrl;

   typedef struct packed {
      logic [15:0] crc;
      logic        ok;
   } done_exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      start, wr_mode, abort, in_valid, out_ready;
   logic [1:0][7:0] in_data;
   logic [1:0]      in_ready, out_valid, busy, done, crc_ok;
   logic [1:0][7:0] out_data;
   logic [1:0][15:0] crc_val;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt [2];
   bit pend     [2];
   int exp_dones[2];

   logic [7:0] blk[$];
   logic [7:0] exp_b0[$], exp_b1[$];
   done_exp_t  exp_d0[$], exp_d1[$];

   always #5 clk = ~clk;

   spi_crc_block_ctrl #(.BLOCK_LEN(9), .CNT_W(4)) u_dut9 (
      .clk(clk), .rst(rst), .start(start[0]), .wr_mode(wr_mode[0]),
      .abort(abort[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .busy(busy[0]), .done(done[0]),
      .crc_ok(crc_ok[0]), .crc_val(crc_val[0])
   );

   spi_crc_block_ctrl #(.BLOCK_LEN(512), .CNT_W(12)) u_dut512 (
      .clk(clk), .rst(rst), .start(start[1]), .wr_mode(wr_mode[1]),
      .abort(abort[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .busy(busy[1]), .done(done[1]),
      .crc_ok(crc_ok[1]), .crc_val(crc_val[1])
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic push_b(input int d, input logic [7:0] b);
      if (d == 0) exp_b0.push_back(b);
      else        exp_b1.push_back(b);
   endtask

   task automatic push_d(input int d, input logic [15:0] crc, input logic ok);
      done_exp_t x;
      x.crc = crc;
      x.ok  = ok;
      if (d == 0) exp_d0.push_back(x);
      else        exp_d1.push_back(x);
      exp_dones[d]++;
   endtask

   // Monitor: one call per instance on every falling edge.
   task automatic mon(input int d);
      done_exp_t x;
      logic [7:0] e;
      bit empty;
      if (pend[d]) begin
         pend[d] = 1'b0;
         empty = (d == 0) ? (exp_d0.size() == 0) : (exp_d1.size() == 0);
         if (empty) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_extra[%0d]: got unexpected done, crc_val 0x%04h", d, crc_val[d]);
         end else begin
            if (d == 0) x = exp_d0.pop_front();
            else        x = exp_d1.pop_front();
            check($sformatf("crc_val[%0d]", d), crc_val[d], x.crc);
            check($sformatf("crc_ok[%0d]", d), {15'h0, crc_ok[d]}, {15'h0, x.ok});
         end
      end
      if (!rst && done[d]) begin
         done_cnt[d]++;
         pend[d] = 1'b1;
      end
      if (!rst && out_valid[d] && out_ready[d]) begin
         empty = (d == 0) ? (exp_b0.size() == 0) : (exp_b1.size() == 0);
         if (empty) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_extra[%0d]: got byte 0x%02h, expected none", d, out_data[d]);
         end else begin
            if (d == 0) e = exp_b0.pop_front();
            else        e = exp_b1.pop_front();
            check($sformatf("out_data[%0d]", d), {8'h0, out_data[d]}, {8'h0, e});
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic set_digits();
      blk.delete();
      for (int i = 0; i < 9; i++) blk.push_back(8'h31 + 8'(i));
   endtask

   // Runs one block on instance d. Returns the number of cycles after the
   // start cycle until the loop ended (done cycle index when done occurs).
   task automatic run_block(input int d, input bit wr, input bit gaps,
                            input int abort_at, input bit stray_start,
                            input bit rst_in_crc, input bit abort_w_start,
                            output int lat);
      int idx = 0;
      int cyc = 0;
      int n0  = done_cnt[d];
      bit hs;
      bit stop = 1'b0;
      wr_mode[d] = wr;
      start[d]   = 1'b1;
      abort[d]   = abort_w_start;
      @(posedge clk); #1;
      start[d] = 1'b0;
      abort[d] = 1'b0;
      while (!stop && done_cnt[d] == n0 && cyc < 3000) begin
         in_valid[d]  = (idx < blk.size()) && (!gaps || $urandom_range(0, 1) == 1);
         in_data[d]   = in_valid[d] ? blk[idx] : 8'h00;
         out_ready[d] = !gaps || $urandom_range(0, 1) == 1;
         start[d]     = stray_start && (cyc == 3 || done[d]);
         if (idx == abort_at) begin
            abort[d]     = 1'b1;
            in_valid[d]  = 1'b1;
            in_data[d]   = blk[idx];
            out_ready[d] = 1'b1;
            stop         = 1'b1;
         end
         if (rst_in_crc && idx == blk.size()) begin
            rst          = 1'b1;
            out_ready[d] = 1'b0;
            stop         = 1'b1;
         end
         @(negedge clk);
         hs = in_valid[d] && in_ready[d];
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b1;
      start[d]     = 1'b0;
      abort[d]     = 1'b0;
      rst          = 1'b0;
      lat          = cyc;
      if (!stop && done_cnt[d] == n0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout[%0d]: got no done after %0d cycles, expected done", d, cyc);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      start = '0; wr_mode = '0; abort = '0; in_valid = '0; out_ready = '1;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_busy[%0d]", d), {15'h0, busy[d]}, 16'h0);
         check($sformatf("rst_in_ready[%0d]", d), {15'h0, in_ready[d]}, 16'h0);
         check($sformatf("rst_out_valid[%0d]", d), {15'h0, out_valid[d]}, 16'h0);
         check($sformatf("rst_out_data[%0d]", d), {8'h0, out_data[d]}, 16'h0);
         check($sformatf("rst_crc_val[%0d]", d), crc_val[d], 16'h0);
         check($sformatf("rst_crc_ok[%0d]", d), {15'h0, crc_ok[d]}, 16'h0);
         check($sformatf("rst_done[%0d]", d), {15'h0, done[d]}, 16'h0);
      end
      // abort alone in IDLE has no effect
      abort[0] = 1'b1;
      idle_cycles(2);
      abort[0] = 1'b0;
      check("idle_abort_busy", {15'h0, busy[0]}, 16'h0);

      // Write "123456789": 11 output bytes, done 12 cycles after start.
      set_digits();
      foreach (blk[i]) push_b(0, blk[i]);
      push_b(0, 8'h31); push_b(0, 8'hC3);
      push_d(0, 16'h31C3, 1'b1);
      run_block(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, lat);
      check("wr_latency", 16'(lat), 16'd12);
      idle_cycles(2);

      // Read 512 x 0xFF with correct then corrupted CRC.
      for (int pass = 0; pass < 2; pass++) begin
         blk.delete();
         for (int i = 0; i < 512; i++) begin
            blk.push_back(8'hFF);
            push_b(1, 8'hFF);
         end
         blk.push_back(8'h7F);
         blk.push_back(pass == 0 ? 8'hA1 : 8'hA0);
         push_d(1, 16'h7FA1, pass == 0);
         run_block(1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, lat);
         idle_cycles(2);
      end

      // Read "123456789" on the short instance: good and bad CRC low byte.
      for (int pass = 0; pass < 2; pass++) begin
         set_digits();
         foreach (blk[i]) push_b(0, blk[i]);
         blk.push_back(8'h31);
         blk.push_back(pass == 0 ? 8'hC3 : 8'hC2);
         push_d(0, 16'h31C3, pass == 0);
         run_block(0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, lat);
         idle_cycles(1);
      end

      // Random bubbles on both sides, write mode.
      for (int rep = 0; rep < 4; rep++) begin
         set_digits();
         foreach (blk[i]) push_b(0, blk[i]);
         push_b(0, 8'h31); push_b(0, 8'hC3);
         push_d(0, 16'h31C3, 1'b1);
         run_block(0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0, lat);
      end
      idle_cycles(1);

      // Abort after 5 bytes (6th byte passes through in the abort cycle).
      set_digits();
      for (int i = 0; i < 6; i++) push_b(0, blk[i]);
      run_block(0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, lat);
      check("abort_busy", {15'h0, busy[0]}, 16'h0);
      check("abort_crc_ok", {15'h0, crc_ok[0]}, 16'h0);
      check("abort_in_ready", {15'h0, in_ready[0]}, 16'h0);
      idle_cycles(2);
      check("abort_no_done", 16'(done_cnt[0]), 16'(exp_dones[0]));

      // Fresh block after abort; start and abort together in IDLE -> start wins.
      set_digits();
      foreach (blk[i]) push_b(0, blk[i]);
      push_b(0, 8'h31); push_b(0, 8'hC3);
      push_d(0, 16'h31C3, 1'b1);
      run_block(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, lat);
      idle_cycles(1);

      // start pulsed during DATA and during DONE is ignored.
      set_digits();
      foreach (blk[i]) push_b(0, blk[i]);
      push_b(0, 8'h31); push_b(0, 8'hC3);
      push_d(0, 16'h31C3, 1'b1);
      run_block(0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0, lat);
      check("stray_start_busy", {15'h0, busy[0]}, 16'h0);
      idle_cycles(4);
      check("stray_start_dones", 16'(done_cnt[0]), 16'(exp_dones[0]));

      // rst while in CRC_HI, then a normal block.
      set_digits();
      foreach (blk[i]) push_b(0, blk[i]);
      run_block(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0, lat);
      check("rst_mid_busy", {15'h0, busy[0]}, 16'h0);
      check("rst_mid_out_valid", {15'h0, out_valid[0]}, 16'h0);
      check("rst_mid_crc_val", crc_val[0], 16'h0);
      idle_cycles(1);
      set_digits();
      foreach (blk[i]) push_b(0, blk[i]);
      push_b(0, 8'h31); push_b(0, 8'hC3);
      push_d(0, 16'h31C3, 1'b1);
      run_block(0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, lat);
      check("post_rst_latency", 16'(lat), 16'd12);
      idle_cycles(3);

      for (int d = 0; d < 2; d++)
         check($sformatf("done_count[%0d]", d), 16'(done_cnt[d]), 16'(exp_dones[d]));
      check("bytes_left[0]", 16'(exp_b0.size()), 16'd0);
      check("bytes_left[1]", 16'(exp_b1.size()), 16'd0);
      check("dones_left[0]", 16'(exp_d0.size()), 16'd0);
      check("dones_left[1]", 16'(exp_d1.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_spi_crc_block_ctrl
